// File: rtl/pio_serial_out.sv
`default_nettype none
// ============================================================================
// Module   : pio_serial_out
// Purpose  : Serial output stage for an Avalon-MM output PIO. Whenever the
//            parallel PIO value changes (or a resend is requested), the value
//            is captured and shifted out MSB-first on a clock/data/latch
//            three-wire link, followed by a latch strobe.
// Ports    : clk          - system clock (rising edge)
//            reset        - asynchronous, active-high reset
//            pio_in       - parallel value from the PIO out_port (DATA_W)
//            resend       - single-cycle pulse, retransmit last-sent value
//            ser_clk      - serial clock, data stable while high
//            ser_data     - serial data, MSB first
//            ser_latch    - latch strobe, CLK_DIV cycles after last bit
//            busy         - frame in progress
//            frame_count  - completed frames, wraps at 16 bits
// Options  : define PIO_SERIAL_OUT_PARITY_EN to append an even-parity bit
//            (XOR of the payload) after the LSB of every frame.
// Revision : 1.0 - initial release
// ============================================================================
module pio_serial_out #(
   parameter int DATA_W  = 11,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] pio_in,
   input  logic              resend,
   output logic              ser_clk,
   output logic              ser_data,
   output logic              ser_latch,
   output logic              busy,
   output logic [15:0]       frame_count
);

`ifdef PIO_SERIAL_OUT_PARITY_EN
   localparam int FRAME_W = DATA_W + 1;
`else
   localparam int FRAME_W = DATA_W;
`endif
   localparam int              BIT_W      = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
   localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(FRAME_W - 1);
   localparam logic [7:0]       c_DIV_LAST = 8'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_LATCH = 2'd2
   } state_t;

   state_t              r_state,       w_state_nxt;
   logic [DATA_W-1:0]   r_last_sent,   w_last_sent_nxt;
   logic [FRAME_W-1:0]  r_shreg,       w_shreg_nxt;
   logic [BIT_W-1:0]    r_bit_cnt,     w_bit_cnt_nxt;
   logic [7:0]          r_div_cnt,     w_div_cnt_nxt;
   logic                r_phase,       w_phase_nxt;
   logic                r_latch,       w_latch_nxt;
   logic                r_busy,        w_busy_nxt;
   logic [15:0]         r_frame_count, w_frame_count_nxt;

   logic [FRAME_W-1:0]  w_frame;
   logic                w_trigger;

`ifdef PIO_SERIAL_OUT_PARITY_EN
   assign w_frame = {pio_in, ^pio_in};
`else
   assign w_frame = pio_in;
`endif

   // A resend and a value change in the same cycle collapse into one frame.
   assign w_trigger = (pio_in != r_last_sent) || resend;

   // ser_data is the shift-register MSB. Zero-fill shifting leaves the
   // register empty after the final bit, so data is 0 in LATCH and IDLE
   // without extra gating.
   assign ser_clk     = r_phase;
   assign ser_data    = r_shreg[FRAME_W-1];
   assign ser_latch   = r_latch;
   assign busy        = r_busy;
   assign frame_count = r_frame_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_last_sent   <= '0;
         r_shreg       <= '0;
         r_bit_cnt     <= '0;
         r_div_cnt     <= '0;
         r_phase       <= 1'b0;
         r_latch       <= 1'b0;
         r_busy        <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_last_sent   <= w_last_sent_nxt;
         r_shreg       <= w_shreg_nxt;
         r_bit_cnt     <= w_bit_cnt_nxt;
         r_div_cnt     <= w_div_cnt_nxt;
         r_phase       <= w_phase_nxt;
         r_latch       <= w_latch_nxt;
         r_busy        <= w_busy_nxt;
         r_frame_count <= w_frame_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_last_sent_nxt   = r_last_sent;
      w_shreg_nxt       = r_shreg;
      w_bit_cnt_nxt     = r_bit_cnt;
      w_div_cnt_nxt     = r_div_cnt;
      w_phase_nxt       = r_phase;
      w_latch_nxt       = r_latch;
      w_busy_nxt        = r_busy;
      w_frame_count_nxt = r_frame_count;

      case (r_state)
         S_IDLE: begin
            if (w_trigger) begin
               w_state_nxt     = S_SHIFT;
               w_shreg_nxt     = w_frame;
               w_last_sent_nxt = pio_in;
               w_bit_cnt_nxt   = '0;
               w_div_cnt_nxt   = '0;
               w_phase_nxt     = 1'b0;
               w_busy_nxt      = 1'b1;
            end
         end

         S_SHIFT: begin
            if (r_div_cnt == c_DIV_LAST) begin
               w_div_cnt_nxt = '0;
               if (!r_phase) begin
                  w_phase_nxt = 1'b1;
               end else begin
                  // End of a bit: drop the clock and present the next bit.
                  w_phase_nxt = 1'b0;
                  w_shreg_nxt = {r_shreg[FRAME_W-2:0], 1'b0};
                  if (r_bit_cnt == c_BIT_LAST) begin
                     w_state_nxt = S_LATCH;
                     w_latch_nxt = 1'b1;
                  end else begin
                     w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                  end
               end
            end else begin
               w_div_cnt_nxt = r_div_cnt + 8'd1;
            end
         end

         S_LATCH: begin
            if (r_div_cnt == c_DIV_LAST) begin
               w_div_cnt_nxt     = '0;
               w_state_nxt       = S_IDLE;
               w_latch_nxt       = 1'b0;
               w_busy_nxt        = 1'b0;
               w_frame_count_nxt = r_frame_count + 16'd1;
            end else begin
               w_div_cnt_nxt = r_div_cnt + 8'd1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = 1'b0;
            w_latch_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_pio_serial_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_serial_out
// Purpose  : Self-checking bench for pio_serial_out (DATA_W=11, CLK_DIV=2).
//            A negedge monitor reconstructs each serial frame (bits sampled
//            on ser_clk rises, busy/latch durations, data stability while
//            ser_clk is high) and the test compares frames against a table
//            of hand-computed payloads, plus directed corner-case sequences.
// Options  : honours PIO_SERIAL_OUT_PARITY_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pio_serial_out;

`ifdef PIO_SERIAL_OUT_PARITY_EN
   localparam int EXP_NBITS = 12;
   localparam int EXP_BUSY  = 50;
`else
   localparam int EXP_NBITS = 11;
   localparam int EXP_BUSY  = 46;
`endif
   localparam int EXP_LATCH = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] pio_in = '0;
   logic        resend = 1'b0;
   logic        ser_clk, ser_data, ser_latch, busy;
   logic [15:0] frame_count;

   pio_serial_out #(.DATA_W(11), .CLK_DIV(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .pio_in      (pio_in),
      .resend      (resend),
      .ser_clk     (ser_clk),
      .ser_data    (ser_data),
      .ser_latch   (ser_latch),
      .busy        (busy),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // ---------------- frame monitor ----------------
   typedef struct {
      logic [15:0] bits;
      int          nbits;
      int          busy_len;
      int          latch_len;
      logic        unstable;
   } frame_t;

   frame_t      frames[$];
   logic [15:0] m_bits;
   int          m_nbits, m_busy, m_latch;
   logic        m_unstable, m_prev_clk, m_prev_data, m_prev_busy;
   logic        m_activity;

   initial begin
      m_bits = '0; m_nbits = 0; m_busy = 0; m_latch = 0;
      m_unstable = 0; m_prev_clk = 0; m_prev_data = 0; m_prev_busy = 0;
      m_activity = 0;
   end

   always @(negedge clk) begin
      if (reset) begin
         m_bits = '0; m_nbits = 0; m_busy = 0; m_latch = 0; m_unstable = 0;
         m_prev_clk = 0; m_prev_data = 0; m_prev_busy = 0;
      end else begin
         if (busy) m_busy++;
         if (ser_latch) m_latch++;
         if (busy || ser_clk || ser_latch) m_activity = 1'b1;
         if (ser_clk && !m_prev_clk) begin
            m_bits = {m_bits[14:0], ser_data};
            m_nbits++;
         end
         if (ser_clk && m_prev_clk && (ser_data != m_prev_data)) m_unstable = 1'b1;
         if (m_prev_busy && !busy) begin
            frames.push_back('{bits: m_bits, nbits: m_nbits, busy_len: m_busy,
                               latch_len: m_latch, unstable: m_unstable});
            m_bits = '0; m_nbits = 0; m_busy = 0; m_latch = 0; m_unstable = 0;
         end
         m_prev_clk  = ser_clk;
         m_prev_data = ser_data;
         m_prev_busy = busy;
      end
   end

   function automatic logic [15:0] exp_frame(input logic [10:0] p, input logic par);
`ifdef PIO_SERIAL_OUT_PARITY_EN
      return {4'b0, p, par};
`else
      return {5'b0, p};
`endif
   endfunction

   // Waits (bounded) for the next completed frame and checks all its fields.
   task automatic check_frame(input string name, input logic [10:0] p,
                              input logic par, input int cnt);
      int     cyc;
      frame_t f;
      cyc = 0;
      while (frames.size() == 0 && cyc < 400) begin
         @(posedge clk);
         cyc++;
      end
      if (frames.size() == 0) begin
         chk({name, "_timeout"}, 32'd0, 32'd1);
      end else begin
         f = frames.pop_front();
         chk({name, "_bits"},   32'(f.bits),      32'(exp_frame(p, par)));
         chk({name, "_nbits"},  32'(f.nbits),     32'(EXP_NBITS));
         chk({name, "_busy"},   32'(f.busy_len),  32'(EXP_BUSY));
         chk({name, "_latch"},  32'(f.latch_len), 32'(EXP_LATCH));
         chk({name, "_stable"}, 32'(f.unstable),  32'd0);
         chk({name, "_count"},  32'(frame_count), 32'(cnt));
      end
   endtask

   task automatic idle_no_frame(input string name, input int cycles);
      repeat (cycles) @(posedge clk);
      chk({name, "_noextra"}, 32'(frames.size()), 32'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [10:0] pio;
      logic        rs;
      logic        par;
      int          cnt;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      vecs[0] = '{pio: 11'h001, rs: 1'b0, par: 1'b1, cnt: 2};
      vecs[1] = '{pio: 11'h001, rs: 1'b1, par: 1'b1, cnt: 3};
      vecs[2] = '{pio: 11'h7FF, rs: 1'b0, par: 1'b1, cnt: 4};
      vecs[3] = '{pio: 11'h123, rs: 1'b0, par: 1'b0, cnt: 5};
      vecs[4] = '{pio: 11'h123, rs: 1'b1, par: 1'b0, cnt: 6};
      vecs[5] = '{pio: 11'h000, rs: 1'b0, par: 1'b0, cnt: 7};
      vecs[6] = '{pio: 11'h5A3, rs: 1'b1, par: 1'b0, cnt: 8};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ser_clk",   32'(ser_clk),     32'd0);
      chk("rst_ser_data",  32'(ser_data),    32'd0);
      chk("rst_ser_latch", 32'(ser_latch),   32'd0);
      chk("rst_busy",      32'(busy),        32'd0);
      chk("rst_count",     32'(frame_count), 32'd0);
      reset = 1'b0;

      // No change after reset: no traffic
      m_activity = 1'b0;
      repeat (200) @(posedge clk);
      chk("nochg_activity", 32'(m_activity),     32'd0);
      chk("nochg_count",    32'(frame_count),    32'd0);
      chk("nochg_frames",   32'(frames.size()),  32'd0);

      // Basic frame with start latency
      @(negedge clk) pio_in = 11'h5A3;
      @(posedge clk); #1;
      chk("lat_busy",  32'(busy),     32'd1);
      chk("lat_msb",   32'(ser_data), 32'd1);
      chk("lat_clk0",  32'(ser_clk),  32'd0);
      @(posedge clk); #1;
      chk("lat_clk1",  32'(ser_clk),  32'd0);
      @(posedge clk); #1;
      chk("lat_rise",  32'(ser_clk),  32'd1);
      check_frame("basic", 11'h5A3, 1'b0, 1);
      idle_no_frame("basic", 20);

      // Table-driven frames
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         pio_in = vecs[i].pio;
         resend = vecs[i].rs;
         @(negedge clk);
         resend = 1'b0;
         check_frame($sformatf("vec%0d", i), vecs[i].pio, vecs[i].par, vecs[i].cnt);
         idle_no_frame($sformatf("vec%0d", i), 20);
      end

      // Coalescing
      @(negedge clk) reset = 1'b1; pio_in = 11'h000;
      @(negedge clk) reset = 1'b0;
      frames.delete();
      @(negedge clk) pio_in = 11'h001;
      repeat (10) @(negedge clk);
      pio_in = 11'h002;
      repeat (10) @(negedge clk);
      pio_in = 11'h7FF;
      check_frame("coal_first", 11'h001, 1'b1, 1);
      check_frame("coal_last",  11'h7FF, 1'b1, 2);
      idle_no_frame("coal", 80);
      chk("coal_count", 32'(frame_count), 32'd2);

      // Resend, with a mid-frame resend that must be ignored
      @(negedge clk) pio_in = 11'h123;
      check_frame("rs_setup", 11'h123, 1'b0, 3);
      repeat (5) @(negedge clk);
      resend = 1'b1;
      @(negedge clk) resend = 1'b0;
      repeat (10) @(negedge clk);
      resend = 1'b1;
      @(negedge clk) resend = 1'b0;
      check_frame("rs_frame", 11'h123, 1'b0, 4);
      idle_no_frame("rs_mid", 80);
      chk("rs_count", 32'(frame_count), 32'd4);

      // Reset during bit 5
      @(negedge clk) pio_in = 11'h5A3;
      cyc = 0;
      while (m_nbits < 5 && cyc < 200) begin
         @(posedge clk);
         cyc++;
      end
      chk("mid_reached_bit5", 32'(m_nbits), 32'd5);
      #2;
      chk("mid_pre_clk", 32'(ser_clk), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_ser_clk",   32'(ser_clk),     32'd0);
      chk("mid_ser_data",  32'(ser_data),    32'd0);
      chk("mid_ser_latch", 32'(ser_latch),   32'd0);
      chk("mid_busy",      32'(busy),        32'd0);
      chk("mid_count",     32'(frame_count), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      frames.delete();
      check_frame("mid_after", 11'h5A3, 1'b0, 1);
      idle_no_frame("mid_after", 20);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
`default_nettype wire
